// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C register-file slave.
// Holds the FSM encoding, the filter counter width and the bus ACK/NACK levels.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } state_t;

  localparam int FLT_CW = 4;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  function automatic logic [7:0] ptr_next(
    input logic [7:0] p,
    input logic [8:0] depth
  );
    if ({1'b0, p} == depth - 9'd1) return 8'd0;
    return p + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Pad-line conditioner: 2-FF synchroniser, stability filter, edge pulses.
// Level, rise and fall all update in the same clock; idle level is high.
module i2c_line_filter
  import i2c_slave_pkg::*;
#(
  parameter int FILTER = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [FLT_CW-1:0] CMAX = FLT_CW'(FILTER - 1);

  logic [1:0]        r_sync;
  logic [FLT_CW-1:0] r_cnt;
  logic              r_level;
  logic              r_rise;
  logic              r_fall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CMAX) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_rise  <= r_sync[1];
        r_fall  <= ~r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_slave_mem.sv
// Oversampled I2C slave with pointer-addressed register file.
// Bits are sampled on SCL rise; SDA changes the clock after SCL fall.
module i2c_slave_mem
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] I2C_ADR   = 7'h10,
  parameter int         MEM_DEPTH = 16,
  parameter int         PTR_W     = 8,
  parameter int         FILTER    = 3
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  output logic       busy_o,
  output logic       wr_stb_o,
  output logic [7:0] wr_adr_o,
  output logic [7:0] wr_dat_o,
  input  logic [7:0] hrd_adr_i,
  output logic [7:0] hrd_dat_o
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [8:0] DEPTH = 9'(MEM_DEPTH);

  state_t r_state;
  state_t w_state_nx;

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop, w_act;
  logic w_adr_hit, w_ptr_ok, w_we;
  logic w_shift_st, w_ack_st;

  logic [PTR_W-1:0] r_sh;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nx;
  logic [7:0]       r_rdsh;
  logic [7:0]       w_rd_cur;
  logic [7:0]       w_rd_nx;
  logic [2:0]       r_bitcnt;
  logic             r_done;
  logic             r_fall_d;
  logic             r_mack;
  logic             r_oen;
  logic             r_busy;
  logic             r_wr_stb;
  logic [7:0]       r_wr_adr;
  logic [7:0]       r_wr_dat;
  logic [7:0]       r_hrd;
  logic [7:0]       r_mem [1 << AW];

  i2c_line_filter #(.FILTER(FILTER)) u_scl (
    .i_clk   (wb_clk_i),
    .i_rst   (arst_i),
    .i_line  (scl_pad_i),
    .o_level (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_filter #(.FILTER(FILTER)) u_sda (
    .i_clk   (wb_clk_i),
    .i_rst   (arst_i),
    .i_line  (sda_pad_i),
    .o_level (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start    = w_sda_fall & w_scl;
  assign w_stop     = w_sda_rise & w_scl;
  // a completed bit is acted on at the SDA update slot after SCL fall
  assign w_act      = r_fall_d & r_done & ~w_start & ~w_stop;
  assign w_adr_hit  = (r_sh[7:1] == I2C_ADR);
  assign w_ptr_ok   = ({1'b0, r_sh} < DEPTH);
  assign w_ptr_nx   = ptr_next(r_ptr, DEPTH);
  assign w_rd_cur   = r_mem[r_ptr[AW-1:0]];
  assign w_rd_nx    = r_mem[w_ptr_nx[AW-1:0]];
  assign w_we       = w_act & (r_state == WDATA);
  assign w_shift_st = r_state inside {ADDR, PTR, WDATA, RDATA};
  assign w_ack_st   = r_state inside {ADDR_ACK, PTR_ACK,
                                      WDATA_ACK, RDATA_ACK};

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (w_start) begin
      w_state_nx = ADDR;
    end else if (w_stop) begin
      w_state_nx = IDLE;
    end else if (w_act) begin
      unique case (r_state)
        ADDR:      w_state_nx = w_adr_hit ? ADDR_ACK : IDLE;
        ADDR_ACK:  w_state_nx = r_sh[0] ? RDATA : PTR;
        PTR:       w_state_nx = w_ptr_ok ? PTR_ACK : IDLE;
        PTR_ACK:   w_state_nx = WDATA;
        WDATA:     w_state_nx = WDATA_ACK;
        WDATA_ACK: w_state_nx = WDATA;
        RDATA:     w_state_nx = RDATA_ACK;
        RDATA_ACK: w_state_nx = (r_mack == ACK) ? RDATA : IDLE;
        default:   w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_fall_d <= 1'b0;
      r_done   <= 1'b0;
      r_bitcnt <= 3'd7;
      r_sh     <= '0;
      r_rdsh   <= '1;
      r_mack   <= NACK;
      r_ptr    <= '0;
      r_oen    <= NACK;
      r_busy   <= 1'b0;
      r_wr_stb <= 1'b0;
      r_wr_adr <= '0;
      r_wr_dat <= '0;
    end else begin
      r_fall_d <= w_scl_fall;
      r_wr_stb <= 1'b0;
      if (w_start) begin
        r_bitcnt <= 3'd7;
        r_done   <= 1'b0;
        r_oen    <= NACK;
      end else if (w_stop) begin
        r_done <= 1'b0;
        r_oen  <= NACK;
        r_busy <= 1'b0;
      end else begin
        if (w_scl_rise && w_shift_st) begin
          r_sh     <= {r_sh[6:0], w_sda};
          r_bitcnt <= r_bitcnt - 3'd1;
          if (r_bitcnt == 3'd0) r_done <= 1'b1;
        end
        if (w_scl_rise && w_ack_st) begin
          r_mack   <= w_sda;
          r_bitcnt <= 3'd7;
          r_done   <= 1'b1;
        end
        if (w_act) begin
          r_done <= 1'b0;
          unique case (r_state)
            ADDR: begin
              r_busy <= w_adr_hit;
              r_oen  <= w_adr_hit ? ACK : NACK;
            end
            ADDR_ACK: begin
              if (r_sh[0]) begin
                r_rdsh <= {w_rd_cur[6:0], 1'b1};
                r_oen  <= w_rd_cur[7];
              end else begin
                r_oen <= NACK;
              end
            end
            PTR: begin
              if (w_ptr_ok) r_ptr <= r_sh;
              r_oen <= w_ptr_ok ? ACK : NACK;
            end
            WDATA: begin
              r_wr_stb <= 1'b1;
              r_wr_adr <= r_ptr;
              r_wr_dat <= r_sh;
              r_ptr    <= w_ptr_nx;
              r_oen    <= ACK;
            end
            RDATA_ACK: begin
              r_ptr <= w_ptr_nx;
              if (r_mack == ACK) begin
                r_rdsh <= {w_rd_nx[6:0], 1'b1};
                r_oen  <= w_rd_nx[7];
              end else begin
                r_oen <= NACK;
              end
            end
            default: r_oen <= NACK;
          endcase
        end else if (r_fall_d && r_state == RDATA) begin
          r_oen  <= r_rdsh[7];
          r_rdsh <= {r_rdsh[6:0], 1'b1};
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < (1 << AW); i++) r_mem[i] <= '0;
      r_hrd <= '0;
    end else begin
      if (w_we) r_mem[r_ptr[AW-1:0]] <= r_sh;
      r_hrd <= ({1'b0, hrd_adr_i} < DEPTH) ?
               r_mem[hrd_adr_i[AW-1:0]] : 8'h00;
    end
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = r_oen;
  assign busy_o       = r_busy;
  assign wr_stb_o     = r_wr_stb;
  assign wr_adr_o     = r_wr_adr;
  assign wr_dat_o     = r_wr_dat;
  assign hrd_dat_o    = r_hrd;

endmodule
